// File: rtl/modulo_period_meter.sv
// Toggle half-period meter: measures intervals between edges of toggle_in,
// compares them to expected, and reports lock, mismatch and stall.
module modulo_period_meter #(
   parameter int CNT_W      = 8,
   parameter int LOCK_COUNT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             toggle_in,
   input  logic [CNT_W-1:0] expected,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             locked,
   output logic             mismatch,
   output logic             timeout
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] MAX = '1;
   localparam logic [MW-1:0] LOCK_N = MW'(LOCK_COUNT);

   typedef enum logic [1:0] {IDLE, ARM, TRACK, LOCKED} state_t;

   state_t           state_q, state_d;
   logic             prev_in;
   logic [CNT_W-1:0] run_cnt, run_d;
   logic [MW-1:0]    match_cnt, match_d, match_inc;
   logic [CNT_W-1:0] period_d, meas;
   logic             locked_d, valid_d, mism_d, tmo_d;
   logic             edge_det, hit;

   assign edge_det  = toggle_in ^ prev_in;
   assign meas      = (run_cnt == MAX) ? MAX : run_cnt + CNT_W'(1);
   assign hit       = (meas == expected);
   assign match_inc = (match_cnt == LOCK_N) ? match_cnt : match_cnt + MW'(1);

   always_comb begin
      state_d  = state_q;
      run_d    = run_cnt;
      match_d  = match_cnt;
      period_d = period;
      locked_d = locked;
      valid_d  = 1'b0;
      mism_d   = 1'b0;
      tmo_d    = 1'b0;
      if (!enable) begin
         state_d  = IDLE;
         run_d    = '0;
         match_d  = '0;
         locked_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               run_d    = '0;
               match_d  = '0;
               locked_d = 1'b0;
               state_d  = ARM;
            end
            // first edge only gives a phase reference, no interval
            ARM: begin
               run_d = '0;
               if (edge_det) state_d = TRACK;
            end
            TRACK, LOCKED: begin
               if (edge_det) begin
                  run_d    = '0;
                  period_d = meas;
                  valid_d  = 1'b1;
                  if (hit) begin
                     match_d = match_inc;
                     if (match_inc == LOCK_N) begin
                        locked_d = 1'b1;
                        state_d  = LOCKED;
                     end
                  end else begin
                     mism_d   = 1'b1;
                     match_d  = '0;
                     locked_d = 1'b0;
                     state_d  = TRACK;
                  end
               end else if (run_cnt == MAX) begin
                  tmo_d    = 1'b1;
                  locked_d = 1'b0;
                  match_d  = '0;
                  run_d    = '0;
                  state_d  = ARM;
               end else begin
                  run_d = run_cnt + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         prev_in      <= 1'b0;
         run_cnt      <= '0;
         match_cnt    <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         mismatch     <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_in      <= toggle_in;
         run_cnt      <= run_d;
         match_cnt    <= match_d;
         period       <= period_d;
         period_valid <= valid_d;
         locked       <= locked_d;
         mismatch     <= mism_d;
         timeout      <= tmo_d;
      end
   end

endmodule
